// File: rtl/assert_event_arbiter_pkg.sv
// Shared types and the round-robin pick function used by the assertion event arbiter.
// The pick function works on a 32-bit maximum vector so any N_SRC up to 32 can reuse it.
package assert_evt_pkg;

    localparam int MAX_SRC  = 32;
    localparam int MAX_ID_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // Returns the first set bit at or after ptr, wrapping at n-1 back to 0.
    function automatic pick_t rr_pick(input logic [MAX_SRC-1:0]  pending,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int                  n);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= n) begin
                j = j - n;
            end
            if ((k < n) && !res.found && pending[j[MAX_ID_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[MAX_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/assert_event_arbiter_if.sv
// Valid/ready report channel carrying the ID of the source being reported.
interface assert_event_arbiter_if #(
    parameter int ID_W = 3
) ();

    logic            rpt_valid;
    logic            rpt_ready;
    logic [ID_W-1:0] rpt_id;

    modport master (
        output rpt_valid,
        output rpt_id,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_id,
        output rpt_ready
    );

endinterface

// File: rtl/assert_event_arbiter_rr.sv
// Round-robin arbiter: combinational rotate-priority pick plus the rotation pointer register.
// The pointer moves to one past the served index whenever a grant is consumed.
module assert_rr_arbiter
    import assert_evt_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] req,
    input  logic             advance,
    input  logic [ID_W-1:0]  adv_idx,
    output logic             grant_found,
    output logic [ID_W-1:0]  grant_idx
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    pick_t           pick;

    always_comb begin
        pick  = rr_pick(MAX_SRC'(req), MAX_ID_W'(ptr_q), N_SRC);
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (adv_idx == ID_W'(N_SRC - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

    // The range guard is always true for legal pointers; it keeps every pick bit in use.
    assign grant_found = pick.found && (int'(pick.idx) < N_SRC);
    assign grant_idx   = pick.idx[ID_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/assert_event_arbiter.sv
// Collects sticky violation flags from assertion monitors and reports them one at a time
// over a valid/ready channel, keeping a saturating count, the first source and drop flags.
module assert_event_arbiter
    import assert_evt_pkg::*;
#(
    parameter int N_SRC         = 8,
    parameter int ID_W          = 3,
    parameter int CNT_W         = 16,
    parameter int HALT_ON_FIRST = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_SRC-1:0]      fire,
    assert_event_arbiter_if.master rpt,
    output logic [CNT_W-1:0]      err_count,
    output logic                  first_valid,
    output logic [ID_W-1:0]       first_id,
    output logic [N_SRC-1:0]      dropped,
    output logic                  halt
);

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   dropped_q, dropped_d;
    logic               rpt_valid_q, rpt_valid_d;
    logic [ID_W-1:0]    rpt_id_q, rpt_id_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               first_valid_q, first_valid_d;
    logic [ID_W-1:0]    first_id_q, first_id_d;
    logic               halt_q, halt_d;

    logic               handshake;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [N_SRC-1:0]   clr_mask;
    logic [N_SRC-1:0]   set_mask;

    assign handshake = rpt_valid_q && rpt.rpt_ready;

    assert_rr_arbiter #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_rr (
        .clock       (clock),
        .reset       (reset),
        .req         (pending_q),
        .advance     (handshake),
        .adv_idx     (rpt_id_q),
        .grant_found (grant_found),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d       = state_q;
        rpt_valid_d   = rpt_valid_q;
        rpt_id_d      = rpt_id_q;
        err_count_d   = err_count_q;
        first_valid_d = first_valid_q;
        first_id_d    = first_id_q;
        halt_d        = halt_q;

        // A fire landing on the cycle its bit is cleared re-arms the bit instead of dropping.
        clr_mask  = handshake ? (N_SRC'(1) << rpt_id_q) : '0;
        set_mask  = en ? fire : '0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
        dropped_d = dropped_q | (set_mask & pending_q & ~clr_mask);

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    rpt_id_d    = grant_idx;
                    rpt_valid_d = 1'b1;
                    state_d     = REPORT;
                end
            end
            REPORT: begin
                if (handshake) begin
                    rpt_valid_d = 1'b0;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    if (!first_valid_q) begin
                        first_valid_d = 1'b1;
                        first_id_d    = rpt_id_q;
                    end
                    if (HALT_ON_FIRST != 0) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HALTED: begin
                rpt_valid_d = 1'b0;
                halt_d      = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                rpt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            dropped_q     <= '0;
            rpt_valid_q   <= 1'b0;
            rpt_id_q      <= '0;
            err_count_q   <= '0;
            first_valid_q <= 1'b0;
            first_id_q    <= '0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            dropped_q     <= dropped_d;
            rpt_valid_q   <= rpt_valid_d;
            rpt_id_q      <= rpt_id_d;
            err_count_q   <= err_count_d;
            first_valid_q <= first_valid_d;
            first_id_q    <= first_id_d;
            halt_q        <= halt_d;
        end
    end

    assign rpt.rpt_valid = rpt_valid_q;
    assign rpt.rpt_id    = rpt_id_q;
    assign err_count     = err_count_q;
    assign first_valid   = first_valid_q;
    assign first_id      = first_id_q;
    assign dropped       = dropped_q;
    assign halt          = halt_q;

endmodule

// File: tb/tb_assert_event_arbiter.sv
// Bench for assert_event_arbiter: a halting instance, a free-running instance with a report
// scoreboard, and a 2-bit-counter instance, all driven from the same stimulus.
module tb_assert_event_arbiter;

    logic       clock;
    logic       reset;
    logic       en;
    logic [7:0] fire;
    logic       ready;

    int errors = 0;
    int checks = 0;

    logic [2:0] sb [$];
    logic [2:0] exp_id;

    assert_event_arbiter_if #(.ID_W(3)) if_h ();
    assert_event_arbiter_if #(.ID_W(3)) if_n ();
    assert_event_arbiter_if #(.ID_W(3)) if_s ();

    assign if_h.rpt_ready = ready;
    assign if_n.rpt_ready = ready;
    assign if_s.rpt_ready = ready;

    logic [15:0] cnt_h, cnt_n;
    logic [1:0]  cnt_s;
    logic        fv_h, fv_n, fv_s;
    logic [2:0]  fid_h, fid_n, fid_s;
    logic [7:0]  drop_h, drop_n, drop_s;
    logic        halt_h, halt_n, halt_s;

    assert_event_arbiter #(.N_SRC(8), .ID_W(3), .CNT_W(16), .HALT_ON_FIRST(1)) dut_h (
        .clock(clock), .reset(reset), .en(en), .fire(fire), .rpt(if_h),
        .err_count(cnt_h), .first_valid(fv_h), .first_id(fid_h), .dropped(drop_h), .halt(halt_h)
    );

    assert_event_arbiter #(.N_SRC(8), .ID_W(3), .CNT_W(16), .HALT_ON_FIRST(0)) dut_n (
        .clock(clock), .reset(reset), .en(en), .fire(fire), .rpt(if_n),
        .err_count(cnt_n), .first_valid(fv_n), .first_id(fid_n), .dropped(drop_n), .halt(halt_n)
    );

    assert_event_arbiter #(.N_SRC(8), .ID_W(3), .CNT_W(2), .HALT_ON_FIRST(0)) dut_s (
        .clock(clock), .reset(reset), .en(en), .fire(fire), .rpt(if_s),
        .err_count(cnt_s), .first_valid(fv_s), .first_id(fid_s), .dropped(drop_s), .halt(halt_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: every accepted report of the free-running instance must match the queue head.
    always @(negedge clock) begin
        if (!reset && if_n.rpt_valid && ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_report got id=%0d, expected no report", if_n.rpt_id);
            end else begin
                exp_id = sb.pop_front();
                if (if_n.rpt_id !== exp_id) begin
                    errors++;
                    $display("[TB] FAIL report_id got=%0d expected=%0d", if_n.rpt_id, exp_id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        fire  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks += 13;
        if (if_n.rpt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0b expected=0", if_n.rpt_valid); end
        if (if_n.rpt_id !== 3'd0)    begin errors++; $display("[TB] FAIL reset_id got=%0d expected=0", if_n.rpt_id); end
        if (cnt_n !== 16'd0)         begin errors++; $display("[TB] FAIL reset_count got=%0d expected=0", cnt_n); end
        if (fv_n !== 1'b0)           begin errors++; $display("[TB] FAIL reset_first_valid got=%0b expected=0", fv_n); end
        if (fid_n !== 3'd0)          begin errors++; $display("[TB] FAIL reset_first_id got=%0d expected=0", fid_n); end
        if (drop_n !== 8'h00)        begin errors++; $display("[TB] FAIL reset_dropped got=%0h expected=0", drop_n); end
        if (halt_n !== 1'b0)         begin errors++; $display("[TB] FAIL reset_halt got=%0b expected=0", halt_n); end
        if (if_h.rpt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_h_valid got=%0b expected=0", if_h.rpt_valid); end
        if (halt_h !== 1'b0)         begin errors++; $display("[TB] FAIL reset_h_halt got=%0b expected=0", halt_h); end
        if (cnt_h !== 16'd0)         begin errors++; $display("[TB] FAIL reset_h_count got=%0d expected=0", cnt_h); end
        if (cnt_s !== 2'd0)          begin errors++; $display("[TB] FAIL reset_s_count got=%0d expected=0", cnt_s); end
        if (drop_s !== 8'h00)        begin errors++; $display("[TB] FAIL reset_s_dropped got=%0h expected=0", drop_s); end
        if (fid_s !== 3'd0 || fv_s !== 1'b0 || halt_s !== 1'b0 || if_s.rpt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_s_misc got fid=%0d fv=%0b halt=%0b valid=%0b expected all 0", fid_s, fv_s, halt_s, if_s.rpt_valid);
        end
    endtask

    task automatic test_single_event();
        do_reset();
        ready = 1'b1;
        sb.push_back(3'd2);
        tick();
        fire = 8'h04;
        tick();
        fire = 8'h00;
        @(negedge clock);
        checks++;
        if (if_h.rpt_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid got=%0b expected=0", if_h.rpt_valid); end
        @(negedge clock);
        checks += 2;
        if (if_h.rpt_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_t2 got=%0b expected=1", if_h.rpt_valid); end
        if (if_h.rpt_id !== 3'd2)    begin errors++; $display("[TB] FAIL single_id got=%0d expected=2", if_h.rpt_id); end
        @(negedge clock);
        checks += 5;
        if (cnt_h !== 16'd1)         begin errors++; $display("[TB] FAIL single_count got=%0d expected=1", cnt_h); end
        if (fv_h !== 1'b1)           begin errors++; $display("[TB] FAIL single_first_valid got=%0b expected=1", fv_h); end
        if (fid_h !== 3'd2)          begin errors++; $display("[TB] FAIL single_first_id got=%0d expected=2", fid_h); end
        if (halt_h !== 1'b1)         begin errors++; $display("[TB] FAIL single_halt got=%0b expected=1", halt_h); end
        if (if_h.rpt_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_after got=%0b expected=0", if_h.rpt_valid); end

        sb.push_back(3'd0);
        tick();
        fire = 8'h01;
        tick();
        fire = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++;
            if (if_h.rpt_valid !== 1'b0 || halt_h !== 1'b1) begin
                errors++;
                $display("[TB] FAIL halted_quiet got valid=%0b halt=%0b expected valid=0 halt=1", if_h.rpt_valid, halt_h);
            end
        end
        sb.push_back(3'd0);
        tick();
        fire = 8'h01;
        tick();
        fire = 8'h00;
        @(negedge clock);
        checks += 3;
        if (drop_h !== 8'h01) begin errors++; $display("[TB] FAIL halted_drop got=%0h expected=01", drop_h); end
        if (drop_n !== 8'h00) begin errors++; $display("[TB] FAIL free_no_drop got=%0h expected=00", drop_n); end
        if (cnt_h !== 16'd1)  begin errors++; $display("[TB] FAIL halted_count got=%0d expected=1", cnt_h); end
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin @(negedge clock); #1; end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL single_drain got=%0d left expected=0", sb.size()); end
    endtask

    task automatic test_round_robin();
        logic exp_v;
        do_reset();
        ready = 1'b1;
        sb.push_back(3'd0);
        sb.push_back(3'd4);
        sb.push_back(3'd7);
        tick();
        fire = 8'h91;
        tick();
        fire = 8'h00;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            exp_v = (k % 2 == 1);
            checks++;
            if (if_n.rpt_valid !== exp_v) begin
                errors++;
                $display("[TB] FAIL rr_valid_cycle%0d got=%0b expected=%0b", k + 1, if_n.rpt_valid, exp_v);
            end
        end
        @(negedge clock);
        checks += 5;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL rr_drain got=%0d left expected=0", sb.size()); end
        if (cnt_n !== 16'd3) begin errors++; $display("[TB] FAIL rr_count got=%0d expected=3", cnt_n); end
        if (fid_n !== 3'd0)  begin errors++; $display("[TB] FAIL rr_first_id got=%0d expected=0", fid_n); end
        if (fv_n !== 1'b1)   begin errors++; $display("[TB] FAIL rr_first_valid got=%0b expected=1", fv_n); end
        if (halt_n !== 1'b0) begin errors++; $display("[TB] FAIL rr_halt got=%0b expected=0", halt_n); end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        sb.push_back(3'd5);
        tick();
        fire = 8'h20;
        tick();
        fire = 8'h00;
        @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checks += 3;
            if (if_n.rpt_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid got=%0b expected=1", if_n.rpt_valid); end
            if (if_n.rpt_id !== 3'd5)    begin errors++; $display("[TB] FAIL bp_id got=%0d expected=5", if_n.rpt_id); end
            if (cnt_n !== 16'd0)         begin errors++; $display("[TB] FAIL bp_count got=%0d expected=0", cnt_n); end
        end
        tick();
        ready = 1'b1;
        @(negedge clock);
        checks += 2;
        if (if_n.rpt_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_valid got=%0b expected=1", if_n.rpt_valid); end
        if (cnt_n !== 16'd0)         begin errors++; $display("[TB] FAIL bp_ready_count got=%0d expected=0", cnt_n); end
        @(negedge clock);
        checks += 3;
        if (cnt_n !== 16'd1)         begin errors++; $display("[TB] FAIL bp_after_count got=%0d expected=1", cnt_n); end
        if (if_n.rpt_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_after_valid got=%0b expected=0", if_n.rpt_valid); end
        if (sb.size() != 0)          begin errors++; $display("[TB] FAIL bp_drain got=%0d left expected=0", sb.size()); end
    endtask

    task automatic test_drop_rearm();
        do_reset();
        ready = 1'b0;
        tick();
        fire = 8'h08;
        tick();
        fire = 8'h00;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (if_n.rpt_valid !== 1'b1 || if_n.rpt_id !== 3'd3) begin
            errors++;
            $display("[TB] FAIL rearm_offer got valid=%0b id=%0d expected valid=1 id=3", if_n.rpt_valid, if_n.rpt_id);
        end
        tick();
        ready = 1'b1;
        fire  = 8'h08;
        sb.push_back(3'd3);
        tick();
        fire = 8'h00;
        sb.push_back(3'd3);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin @(negedge clock); #1; end
        @(negedge clock);
        checks += 3;
        if (sb.size() != 0)   begin errors++; $display("[TB] FAIL rearm_drain got=%0d left expected=0", sb.size()); end
        if (drop_n !== 8'h00) begin errors++; $display("[TB] FAIL rearm_dropped got=%0h expected=00", drop_n); end
        if (cnt_n !== 16'd2)  begin errors++; $display("[TB] FAIL rearm_count got=%0d expected=2", cnt_n); end

        tick();
        ready = 1'b0;
        fire  = 8'h08;
        tick();
        fire = 8'h00;
        tick();
        fire = 8'h08;
        tick();
        fire = 8'h00;
        @(negedge clock);
        checks++;
        if (drop_n !== 8'h08) begin errors++; $display("[TB] FAIL drop_set got=%0h expected=08", drop_n); end
        sb.push_back(3'd3);
        tick();
        ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin @(negedge clock); #1; end
        @(negedge clock);
        @(negedge clock);
        checks += 3;
        if (sb.size() != 0)   begin errors++; $display("[TB] FAIL drop_drain got=%0d left expected=0", sb.size()); end
        if (drop_n !== 8'h08) begin errors++; $display("[TB] FAIL drop_sticky got=%0h expected=08", drop_n); end
        if (cnt_n !== 16'd3)  begin errors++; $display("[TB] FAIL drop_count got=%0d expected=3", cnt_n); end
    endtask

    task automatic test_saturation();
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 5; k++) sb.push_back(3'(k));
        tick();
        fire = 8'h1F;
        tick();
        fire = 8'h00;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin @(negedge clock); #1; end
        @(negedge clock);
        checks += 3;
        if (sb.size() != 0)  begin errors++; $display("[TB] FAIL sat_drain got=%0d left expected=0", sb.size()); end
        if (cnt_s !== 2'd3)  begin errors++; $display("[TB] FAIL sat_count got=%0d expected=3", cnt_s); end
        if (cnt_n !== 16'd5) begin errors++; $display("[TB] FAIL sat_wide_count got=%0d expected=5", cnt_n); end
    endtask

    task automatic test_reset_mid_report();
        do_reset();
        ready = 1'b0;
        tick();
        fire = 8'h40;
        tick();
        fire = 8'h00;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (if_n.rpt_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_offer got=%0b expected=1", if_n.rpt_valid); end
        tick();
        reset = 1'b1;
        ready = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks += 4;
        if (if_n.rpt_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got=%0b expected=0", if_n.rpt_valid); end
        if (if_n.rpt_id !== 3'd0)    begin errors++; $display("[TB] FAIL mid_id got=%0d expected=0", if_n.rpt_id); end
        if (cnt_n !== 16'd0)         begin errors++; $display("[TB] FAIL mid_count got=%0d expected=0", cnt_n); end
        if (fv_n !== 1'b0)           begin errors++; $display("[TB] FAIL mid_first_valid got=%0b expected=0", fv_n); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if (if_n.rpt_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_pending_cleared got=%0b expected=0", if_n.rpt_valid); end
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        ready = 1'b1;
        tick();
        en   = 1'b0;
        fire = 8'hFF;
        tick();
        fire = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if (if_n.rpt_valid !== 1'b0) begin errors++; $display("[TB] FAIL en_gated got=%0b expected=0", if_n.rpt_valid); end
        end
        tick();
        en    = 1'b1;
        ready = 1'b0;
        fire  = 8'h02;
        sb.push_back(3'd1);
        tick();
        fire = 8'h00;
        en   = 1'b0;
        tick();
        ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin @(negedge clock); #1; end
        @(negedge clock);
        checks += 2;
        if (sb.size() != 0)  begin errors++; $display("[TB] FAIL en_pending_drain got=%0d left expected=0", sb.size()); end
        if (cnt_n !== 16'd1) begin errors++; $display("[TB] FAIL en_pending_count got=%0d expected=1", cnt_n); end
        en = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        fire  = 8'h00;
        ready = 1'b0;
        test_reset();
        test_single_event();
        test_round_robin();
        test_backpressure();
        test_drop_rearm();
        test_saturation();
        test_reset_mid_report();
        test_enable_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
